// File: rtl/peripheral_msi_bus_scheduler.sv
// Round-robin Wishbone scheduler: shares one slave port among NUM_PORTS masters for
// whole bus cycles, with a stall watchdog that aborts hung cycles with an error.
module peripheral_msi_bus_scheduler #(
    parameter int unsigned NUM_PORTS = 6,
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_PORTS*AW-1:0]     m_adr_i,
    input  logic [NUM_PORTS*DW-1:0]     m_dat_i,
    input  logic [NUM_PORTS*DW/8-1:0]   m_sel_i,
    input  logic [NUM_PORTS-1:0]        m_we_i,
    input  logic [NUM_PORTS-1:0]        m_cyc_i,
    input  logic [NUM_PORTS-1:0]        m_stb_i,
    output logic [DW-1:0]               m_dat_o,
    output logic [NUM_PORTS-1:0]        m_ack_o,
    output logic [NUM_PORTS-1:0]        m_err_o,
    output logic [AW-1:0]               s_adr_o,
    output logic [DW-1:0]               s_dat_o,
    output logic [DW/8-1:0]             s_sel_o,
    output logic                        s_we_o,
    output logic                        s_cyc_o,
    output logic                        s_stb_o,
    input  logic [DW-1:0]               s_dat_i,
    input  logic                        s_ack_i,
    input  logic                        s_err_i,
    output logic [NUM_PORTS-1:0]        grant_o,
    output logic                        timeout_o
);

    localparam int unsigned SW = DW / 8;
    localparam int unsigned OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] WD_LAST   = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [OW-1:0] LAST_PORT = OW'(NUM_PORTS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_OWN   = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t          r_state;
    logic [OW-1:0]   r_owner;
    logic [OW-1:0]   r_ptr;
    logic [CW-1:0]   r_wdog;
    logic            r_timeout;

    logic [AW-1:0]   w_adr [NUM_PORTS];
    logic [DW-1:0]   w_dat [NUM_PORTS];
    logic [SW-1:0]   w_sel [NUM_PORTS];
    logic            w_own;
    logic            w_abort;
    logic            w_stall;
    logic            w_found;
    logic [OW-1:0]   w_winner;
    logic [OW-1:0]   w_idx;
    logic [OW-1:0]   w_ptr_next;
    logic [NUM_PORTS-1:0] w_onehot;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_adr[g] = m_adr_i[g*AW +: AW];
        assign w_dat[g] = m_dat_i[g*DW +: DW];
        assign w_sel[g] = m_sel_i[g*SW +: SW];
    end

    // First requesting port at or above the rotation pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            w_idx = OW'((32'(r_ptr) + i) % NUM_PORTS);
            if (!w_found && m_cyc_i[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_own      = (r_state == S_OWN);
    assign w_abort    = (r_state == S_ABORT);
    assign w_onehot   = NUM_PORTS'(1) << r_owner;
    assign w_ptr_next = (r_owner == LAST_PORT) ? '0 : r_owner + 1'b1;

    assign s_adr_o   = w_own ? w_adr[r_owner] : '0;
    assign s_dat_o   = w_own ? w_dat[r_owner] : '0;
    assign s_sel_o   = w_own ? w_sel[r_owner] : '0;
    assign s_we_o    = w_own & m_we_i[r_owner];
    assign s_cyc_o   = w_own & m_cyc_i[r_owner];
    assign s_stb_o   = w_own & m_stb_i[r_owner];
    assign w_stall   = s_stb_o & ~s_ack_i & ~s_err_i;

    // Slave responses reach only the owner; an abort reports a single err beat.
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = (w_own && s_ack_i) ? w_onehot : '0;
    assign m_err_o   = ((w_own && s_err_i) || (w_abort && r_timeout)) ? w_onehot : '0;
    assign grant_o   = (w_own || w_abort) ? w_onehot : '0;
    assign timeout_o = r_timeout;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_owner   <= '0;
            r_ptr     <= '0;
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_wdog <= '0;
                    if (w_found) begin
                        r_owner <= w_winner;
                        r_state <= S_OWN;
                    end
                end
                S_OWN: begin
                    if (!m_cyc_i[r_owner]) begin
                        r_state <= S_IDLE;
                        r_ptr   <= w_ptr_next;
                        r_wdog  <= '0;
                    end else if (TIMEOUT != 0 && w_stall) begin
                        if (r_wdog == WD_LAST) begin
                            r_state   <= S_ABORT;
                            r_timeout <= 1'b1;
                            r_wdog    <= '0;
                        end else begin
                            r_wdog <= r_wdog + 1'b1;
                        end
                    end else begin
                        r_wdog <= '0;
                    end
                end
                S_ABORT: begin
                    if (!m_cyc_i[r_owner]) begin
                        r_state <= S_IDLE;
                        r_ptr   <= w_ptr_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_msi_bus_scheduler.sv
// Bench for peripheral_msi_bus_scheduler: directed reset/routing/watchdog checks plus a
// scoreboard that predicts round-robin grant order for randomized request batches.
module tb_peripheral_msi_bus_scheduler;

    localparam int unsigned N  = 6;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;
    localparam int unsigned TO = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N*AW-1:0]   m_adr_i = '0;
    logic [N*DW-1:0]   m_dat_i = '0;
    logic [N*SW-1:0]   m_sel_i = '0;
    logic [N-1:0]      m_we_i  = '0;
    logic [N-1:0]      m_cyc_i = '0;
    logic [N-1:0]      m_stb_i = '0;
    logic [DW-1:0]     m_dat_o;
    logic [N-1:0]      m_ack_o;
    logic [N-1:0]      m_err_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [DW-1:0]     s_dat_i = '0;
    logic              s_ack_i = 1'b0;
    logic              s_err_i = 1'b0;
    logic [N-1:0]      grant_o;
    logic              timeout_o;

    peripheral_msi_bus_scheduler #(
        .NUM_PORTS(N), .AW(AW), .DW(DW), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [AW-1:0] t_adr [N];
    logic [DW-1:0] t_dat [N];
    logic [SW-1:0] t_sel [N];
    logic          t_we  [N];
    int            beats [N];
    int            exp_q [$];
    int            mptr = 0;
    int            stall_n = 0;
    int            cur = 0;
    bit            mon_en = 1'b0;
    logic [N-1:0]  prev_g = '0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [N-1:0] oh(input int p);
        oh = N'(1) << p;
    endfunction

    task automatic load(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, input logic w);
        t_adr[k] = a; t_dat[k] = d; t_sel[k] = s; t_we[k] = w;
        m_adr_i[k*AW +: AW] = a;
        m_dat_i[k*DW +: DW] = d;
        m_sel_i[k*SW +: SW] = s;
        m_we_i[k] = w;
    endtask

    // Raise a request on port k carrying random payload, lasting nb acked beats.
    task automatic start(input int k, input int nb);
        load(k, $urandom, $urandom, SW'($urandom), 1'($urandom));
        m_cyc_i[k] = 1'b1;
        m_stb_i[k] = 1'b1;
        beats[k]   = nb;
    endtask

    // One clock of the master models and of a slave that never stalls 3 cycles in a row.
    task automatic step();
        @(negedge clk);
        for (int k = 0; k < N; k++)
            if (m_cyc_i[k] && m_ack_o[k]) beats[k]--;
        @(posedge clk);
        #2;
        for (int k = 0; k < N; k++)
            if (m_cyc_i[k] && beats[k] <= 0) begin
                m_cyc_i[k] = 1'b0;
                m_stb_i[k] = 1'b0;
            end
        if (stall_n >= 2 || $urandom_range(1, 0) == 1) begin
            s_ack_i = 1'b1;
            stall_n = 0;
        end else begin
            s_ack_i = 1'b0;
            stall_n++;
        end
        s_dat_i = $urandom;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((m_cyc_i != '0 || exp_q.size() != 0) && n < limit) begin
            step();
            n++;
        end
        n_chk++;
        if (n >= limit) begin
            n_fail++;
            $display("FAIL wait_idle: still busy after %0d cycles, %0d grants outstanding",
                     limit, exp_q.size());
            exp_q.delete();
            m_cyc_i = '0;
            m_stb_i = '0;
        end
        repeat (2) step();
    endtask

    task automatic reset_dut();
        m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #4 rst = 1'b1;
    endtask

    // Simultaneous batch: grants follow port order starting from the pointer, with wrap.
    task automatic run_batch();
        logic [N-1:0] sub;
        int k;
        int last;
        sub  = N'($urandom_range((1 << N) - 1, 1));
        last = mptr;
        for (int i = 0; i < N; i++)
            if (sub[i]) start(i, int'($urandom_range(3, 1)));
        for (int i = 0; i < N; i++) begin
            k = (mptr + i) % N;
            if (sub[k]) begin
                exp_q.push_back(k);
                last = k;
            end
        end
        mptr = (last + 1) % N;
        wait_idle(200);
    endtask

    initial begin
        int  n;
        bit  seen0;
        bit  rearm;

        fork
            forever begin
                @(negedge clk);
                if (mon_en) begin
                    if (grant_o != '0 && grant_o != prev_g) begin
                        if (exp_q.size() == 0) begin
                            n_chk++;
                            n_fail++;
                            $display("FAIL sb_grant: unexpected grant 0x%0h at %0t", grant_o, $time);
                        end else begin
                            cur = exp_q.pop_front();
                            chk("sb_grant", 64'(grant_o), 64'(oh(cur)));
                            chk("sb_dead_cycle", 64'(prev_g), 64'(0));
                        end
                    end
                    if (grant_o != '0 && s_stb_o && s_ack_i) begin
                        chk("sb_adr", 64'(s_adr_o), 64'(t_adr[cur]));
                        chk("sb_dat", 64'(s_dat_o), 64'(t_dat[cur]));
                        chk("sb_sel", 64'(s_sel_o), 64'(t_sel[cur]));
                        chk("sb_we", 64'(s_we_o), 64'(t_we[cur]));
                        chk("sb_ack", 64'(m_ack_o), 64'(oh(cur)));
                        chk("sb_rdata", 64'(m_dat_o), 64'(s_dat_i));
                        chk("sb_no_err", 64'({m_err_o, timeout_o}), 64'(0));
                    end
                    if (grant_o == '0)
                        chk("sb_idle_quiet", 64'({s_cyc_o, s_stb_o, m_ack_o, m_err_o}), 64'(0));
                end
                prev_g = grant_o;
            end
        join_none

        // Reset held with every master requesting.
        for (int k = 0; k < N; k++) start(k, 1);
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234_5678;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 64'(grant_o), 64'(0));
        chk("rst_s_cyc_stb", 64'({s_cyc_o, s_stb_o, s_we_o}), 64'(0));
        chk("rst_m_ack_err", 64'({m_ack_o, m_err_o}), 64'(0));
        chk("rst_timeout", 64'(timeout_o), 64'(0));
        chk("rst_s_adr", 64'(s_adr_o), 64'(0));
        chk("rst_rdata", 64'(m_dat_o), 64'h1234_5678);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst_arb_latency", 64'(grant_o), 64'(0));
        @(negedge clk);
        chk("rst_first_grant", 64'(grant_o), 64'(6'b000001));
        chk("rst_first_cyc", 64'(s_cyc_o), 64'(1));
        chk("rst_first_adr", 64'(s_adr_o), 64'(t_adr[0]));
        chk("rst_first_ack", 64'(m_ack_o), 64'(6'b000001));
        @(posedge clk);
        #2 m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        repeat (2) @(posedge clk);

        // Routing of owner 3's write, then ack and err forwarding.
        reset_dut();
        load(3, 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1);
        m_cyc_i[3] = 1'b1; m_stb_i[3] = 1'b1;
        @(negedge clk);
        chk("route_latency", 64'(grant_o), 64'(0));
        @(negedge clk);
        chk("route_grant", 64'(grant_o), 64'(6'b001000));
        chk("route_adr", 64'(s_adr_o), 64'h100);
        chk("route_dat", 64'(s_dat_o), 64'hDEAD_BEEF);
        chk("route_sel", 64'(s_sel_o), 64'hF);
        chk("route_we_cyc_stb", 64'({s_we_o, s_cyc_o, s_stb_o}), 64'(3'b111));
        chk("route_no_ack", 64'(m_ack_o), 64'(0));
        #1 s_ack_i = 1'b1; s_dat_i = 32'hCAFE_F00D;
        #1;
        chk("route_ack", 64'(m_ack_o), 64'(6'b001000));
        chk("route_rdata", 64'(m_dat_o), 64'hCAFE_F00D);
        @(posedge clk);
        #2 s_ack_i = 1'b0; s_err_i = 1'b1; m_we_i[3] = 1'b0;
        #1;
        chk("route_err", 64'(m_err_o), 64'(6'b001000));
        chk("route_err_no_ack", 64'(m_ack_o), 64'(0));
        chk("route_read_we", 64'(s_we_o), 64'(0));
        @(posedge clk);
        #2 s_err_i = 1'b0; m_cyc_i[3] = 1'b0; m_stb_i[3] = 1'b0;
        #1;
        chk("route_drop_cyc", 64'(s_cyc_o), 64'(0));
        chk("route_drop_grant", 64'(grant_o), 64'(6'b001000));
        @(posedge clk);
        #3;
        chk("route_release", 64'(grant_o), 64'(0));

        // Watchdog expiry after TIMEOUT stalled cycles.
        reset_dut();
        load(2, $urandom, $urandom, 4'hF, 1'b0);
        m_cyc_i[2] = 1'b1; m_stb_i[2] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_stall_no_err", 64'({m_err_o, timeout_o}), 64'(0));
            chk("wd_stall_cyc", 64'(s_cyc_o), 64'(1));
        end
        @(negedge clk);
        chk("wd_err_pulse", 64'(m_err_o), 64'(6'b000100));
        chk("wd_timeout_pulse", 64'(timeout_o), 64'(1));
        chk("wd_abort_cyc_stb", 64'({s_cyc_o, s_stb_o}), 64'(0));
        chk("wd_abort_grant", 64'(grant_o), 64'(6'b000100));
        #1 s_ack_i = 1'b1;
        #1;
        chk("wd_abort_no_ack", 64'(m_ack_o), 64'(0));
        @(negedge clk);
        chk("wd_err_once", 64'({m_err_o, timeout_o}), 64'(0));
        chk("wd_abort_hold", 64'(grant_o), 64'(6'b000100));
        @(posedge clk);
        #2 m_cyc_i = '0; m_stb_i = '0; s_ack_i = 1'b0;
        @(posedge clk);
        #3;
        chk("wd_abort_release", 64'(grant_o), 64'(0));

        // Ack landing on the last stalled cycle beats the watchdog.
        reset_dut();
        load(4, $urandom, $urandom, 4'h3, 1'b1);
        m_cyc_i[4] = 1'b1; m_stb_i[4] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wd_race_stall", 64'({m_err_o, timeout_o}), 64'(0));
        end
        @(posedge clk);
        #2 s_ack_i = 1'b1;
        @(negedge clk);
        chk("wd_race_ack", 64'(m_ack_o), 64'(6'b010000));
        chk("wd_race_no_err", 64'(m_err_o), 64'(0));
        @(posedge clk);
        #2 s_ack_i = 1'b0;
        @(negedge clk);
        chk("wd_race_no_timeout", 64'({m_err_o, timeout_o}), 64'(0));
        chk("wd_race_still_own", 64'({grant_o, s_cyc_o}), 64'({6'b010000, 1'b1}));
        @(posedge clk);
        #2 m_cyc_i = '0; m_stb_i = '0;
        @(posedge clk);
        #3;
        chk("wd_race_release", 64'(grant_o), 64'(0));

        // Async reset while owning; pointer (5 here) must restart at 0.
        load(3, $urandom, $urandom, 4'hF, 1'b1);
        m_cyc_i[3] = 1'b1; m_stb_i[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ar_owner", 64'(grant_o), 64'(6'b001000));
        #2 rst = 1'b0;
        #1;
        chk("ar_cyc_drop", 64'(s_cyc_o), 64'(0));
        chk("ar_grant_drop", 64'(grant_o), 64'(0));
        load(5, $urandom, $urandom, 4'hF, 1'b0);
        m_cyc_i[5] = 1'b1; m_stb_i[5] = 1'b1;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("ar_idle_after", 64'(grant_o), 64'(0));
        @(negedge clk);
        chk("ar_ptr_restart", 64'(grant_o), 64'(6'b001000));
        @(posedge clk);
        #2 m_cyc_i = '0; m_stb_i = '0;
        repeat (2) @(posedge clk);

        // Round-robin through all six, port 0 re-requests and wins again last.
        reset_dut();
        stall_n = 0;
        mon_en  = 1'b1;
        for (int k = 0; k < N; k++) start(k, 1);
        for (int k = 0; k < N; k++) exp_q.push_back(k);
        exp_q.push_back(0);
        seen0 = 1'b0;
        rearm = 1'b0;
        n = 0;
        while (!rearm && n < 200) begin
            step();
            n++;
            if (!m_cyc_i[0]) begin
                if (seen0) begin
                    start(0, 1);
                    rearm = 1'b1;
                end else begin
                    seen0 = 1'b1;
                end
            end
        end
        wait_idle(300);

        // Port 1 holds for 10 beats; 0 and 5 wait, then pointer 2 favours 5.
        reset_dut();
        start(1, 10);
        exp_q.push_back(1);
        step();
        step();
        start(0, 1);
        start(5, 1);
        exp_q.push_back(5);
        exp_q.push_back(0);
        wait_idle(300);

        // Randomized request batches against the round-robin model.
        reset_dut();
        mptr = 0;
        repeat (30) run_batch();
        mon_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/peripheral_msi_bus_scheduler.md
# peripheral_msi_bus_scheduler

Shares one Wishbone slave port between `NUM_PORTS` Wishbone masters in the MSI peripheral fabric. It is a transaction-level scheduler: round-robin arbitration picks an owner, the owner's bus cycle is routed to the slave for the full duration of its `cyc`, and a watchdog aborts stalled cycles with an error. It sits between the master-side interconnect and a shared slave (memory, bridge).

## Interface
- `NUM_PORTS`, 6, number of masters (≥2)
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `TIMEOUT`, 255, max stalled cycles before abort; 0 disables watchdog

- `clk`  input  1  clock
- `rst`  input  1  asynchronous active-low reset
- `m_adr_i`  input  NUM_PORTS*AW  master addresses, port k at [k*AW +: AW]
- `m_dat_i`  input  NUM_PORTS*DW  master write data
- `m_sel_i`  input  NUM_PORTS*DW/8  master byte selects
- `m_we_i`, `m_cyc_i`, `m_stb_i`  input  NUM_PORTS  per-master controls
- `m_dat_o`  output  DW  read data, broadcast to all masters
- `m_ack_o`, `m_err_o`  output  NUM_PORTS  per-master ack/err
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`  output  AW/DW/DW/8/1/1/1  slave request
- `s_dat_i`, `s_ack_i`, `s_err_i`  input  DW/1/1  slave response
- `grant_o`  output  NUM_PORTS  one-hot owner, 0 when no owner
- `timeout_o`  output  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, OWN, ABORT. Registered: state, owner index, rotation pointer, watchdog counter (width `$clog2(TIMEOUT+1)`, min 1).
- IDLE: no owner; all `s_*_o` and `m_ack_o`/`m_err_o` = 0. If any `m_cyc_i` set, winner = first set `m_cyc_i` searching upward from pointer with wrap; latch owner, go OWN.
- Pointer: after owner k releases (OWN/ABORT → IDLE), pointer = (k+1) mod NUM_PORTS. Reset pointer = 0.
- OWN: `s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o` = owner's inputs (combinational mux). `m_ack_o[owner]` = `s_ack_i`, `m_err_o[owner]` = `s_err_i`; all other bits 0. `m_dat_o` = `s_dat_i` always. Owner `m_cyc_i` low → IDLE next edge (s_cyc_o follows combinationally same cycle). Other masters' `cyc` ignored until then.
- Watchdog (TIMEOUT>0): in OWN, counter increments each cycle with `s_stb_o`=1 and `s_ack_i`=`s_err_i`=0; clears on ack, err, or `s_stb_o`=0. When counter = TIMEOUT−1 and still stalled: go ABORT, `timeout_o`=1 next cycle.
- ABORT: `s_cyc_o`=`s_stb_o`=0; `m_err_o[owner]`=1 on first ABORT cycle only, then 0; slave ack/err not forwarded. Owner `m_cyc_i` low → IDLE.
- Ack/err and watchdog expiry in same cycle: ack/err wins, counter clears, stay OWN.
- `grant_o` = one-hot owner in OWN and ABORT, 0 in IDLE.

## Timing
- Reset (rst=0, async): state IDLE, owner 0, pointer 0, counter 0, `timeout_o` 0; hence all outputs 0 (`m_dat_o` = `s_dat_i`). Reset mid-transaction drops `s_cyc_o` immediately.
- Arbitration latency: `m_cyc_i` rising in IDLE at edge t → `s_cyc_o`/`grant_o` high from edge t+1.
- Slave response to master: zero cycles (combinational).
- Handover: owner drops cyc in cycle c → IDLE in c+1 → next owner OWN in c+2 (one dead cycle minimum).
- Abort: stalled stb from cycle s → ABORT entered at edge s+TIMEOUT; `m_err_o[owner]` and `timeout_o` high that cycle only.
- Single requester repeatedly re-requesting is granted each time (no starvation by empty ports).

## Test plan
- Reset: hold rst=0 with all `m_cyc_i`=1 → all outputs 0; release → port 0 granted one cycle later, `grant_o`=000001.
- Round-robin: all 6 masters hold cyc, each drops after 1 ack → grant order 0,1,2,3,4,5,0 with one idle cycle between owners.
- Routing: owner 3 writes adr 0x100, dat 0xDEADBEEF, sel 0xF → slave sees exactly these; `s_ack_i`=1 → `m_ack_o`=001000 same cycle.
- Watchdog: TIMEOUT=4, slave never acks → `m_err_o[owner]` and `timeout_o` pulse at 4th stalled cycle, `s_cyc_o`=0; ack arriving exactly on 4th cycle → ack forwarded, no err.
- Hold: owner 1 keeps cyc across 10 stb/ack beats while port 0 requests → port 0 granted only after port 1 releases, pointer then 2.
- Async reset mid-OWN: rst falls between edges → `s_cyc_o`,`grant_o` 0 immediately; after release pointer restarts at 0.
